// File: rtl/dsi_pkg.sv
// Shared definitions for the DSI clock path: divider decode, expected
// reference interval and the clock-monitor state encoding.
package dsi_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2
    } mon_state_e;

    // Same mapping the clock generator applies to dsi_ctrl0[1:0].
    function automatic logic [2:0] div_decode(input logic [1:0] sel);
        case (sel)
            2'b01:   return 3'd1;
            2'b00:   return 3'd2;
            2'b10:   return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    // dsi_clk cycles per 4-pclk reference half-period: 12/DIV.
    function automatic logic [7:0] exp_count(input logic [1:0] sel);
        case (div_decode(sel))
            3'd1:    return 8'd12;
            3'd2:    return 8'd6;
            3'd3:    return 8'd4;
            default: return 8'd3;
        endcase
    endfunction

endpackage

// File: rtl/dsi_sync2.sv
// Generic two-flop synchronizer for pclk -> dsi_clk level crossings.
module dsi_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge i_clk) begin
        r_s1 <= i_d;
        r_s2 <= r_s1;
    end

    assign o_q = r_s2;

endmodule

// File: rtl/dsi_clk_monitor.sv
// Measures dsi_clk cycles between reference-toggle edges and tracks whether
// the generated clock runs at the ratio selected by div_sel.
module dsi_clk_monitor #(
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4,
    parameter int ERR_CNT  = 2,
    parameter int TIMEOUT  = 63
) (
    input  logic       dsi_clk,
    input  logic       rst_n,
    input  logic [1:0] div_sel,
    input  logic       ref_tgl,
    input  logic       clr_err,
    output logic [7:0] meas_cnt,
    output logic       meas_valid,
    output logic       locked,
    output logic       freq_err,
    output logic       timeout_err
);
    import dsi_pkg::*;

    localparam logic [7:0]        LOCK_N = 8'(LOCK_CNT);
    localparam logic [7:0]        ERR_N  = 8'(ERR_CNT);
    localparam logic [7:0]        TMO_N  = 8'(TIMEOUT);
    localparam logic signed [9:0] TOL_S  = 10'(TOL);

    function automatic logic interval_ok(input logic [7:0] meas, input logic [7:0] expv);
        logic signed [9:0] diff;
        diff = $signed({2'b00, meas}) - $signed({2'b00, expv});
        return (diff <= TOL_S) && (diff >= -TOL_S);
    endfunction

    logic       w_ref_s2;
    logic       r_ref_s3;
    logic       w_edge;
    logic [1:0] r_div_q;
    logic       w_div_chg;
    logic       w_tmo;
    logic       w_prime_edge;
    logic       w_meas_edge;
    logic       w_good;

    logic [7:0] r_cnt;
    logic [7:0] r_meas_cnt;
    logic       r_meas_valid;
    logic       r_prime;

    mon_state_e r_state, w_state_nxt;
    logic [7:0] r_good_cnt, w_good_nxt;
    logic [7:0] r_bad_cnt, w_bad_nxt;
    logic       w_ferr_set;
    logic       r_freq_err;
    logic       r_timeout_err;

    dsi_sync2 #(.WIDTH(1)) u_ref_sync (
        .i_clk (dsi_clk),
        .i_d   (ref_tgl),
        .o_q   (w_ref_s2)
    );

    // Third flop and divider copy carry no reset: they simply track their inputs.
    always_ff @(posedge dsi_clk) begin
        r_ref_s3 <= w_ref_s2;
        r_div_q  <= div_sel;
    end

    assign w_edge      = w_ref_s2 ^ r_ref_s3;
    assign w_div_chg   = (div_sel != r_div_q);
    assign w_tmo       = (r_cnt == TMO_N);
    // A divider change or timeout in the edge cycle makes that edge the priming one.
    assign w_prime_edge = w_edge && (r_prime || w_div_chg || w_tmo);
    assign w_meas_edge  = w_edge && !w_prime_edge;
    assign w_good       = interval_ok(r_meas_cnt, exp_count(div_sel));

    // Stage p0: interval counter and measurement register
    always_ff @(posedge dsi_clk) begin
        if (!rst_n) begin
            r_cnt        <= 8'd0;
            r_meas_cnt   <= 8'd0;
            r_meas_valid <= 1'b0;
            r_prime      <= 1'b1;
        end else begin
            r_meas_valid <= w_meas_edge;
            if (w_meas_edge)
                r_meas_cnt <= r_cnt;
            if (w_edge)
                r_cnt <= 8'd1;
            else if (r_cnt != 8'hFF)
                r_cnt <= r_cnt + 8'd1;
            if (w_edge)
                r_prime <= 1'b0;
            else if (w_div_chg || w_tmo)
                r_prime <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_bad_nxt   = r_bad_cnt;
        w_ferr_set  = 1'b0;
        if (w_div_chg || w_tmo) begin
            w_state_nxt = ST_UNLOCKED;
            w_good_nxt  = 8'd0;
            w_bad_nxt   = 8'd0;
        end else if (r_meas_valid) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_good) begin
                        w_state_nxt = ST_LOCKING;
                        w_good_nxt  = 8'd1;
                    end
                end
                ST_LOCKING: begin
                    if (!w_good) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_good_nxt  = 8'd0;
                    end else if (r_good_cnt + 8'd1 >= LOCK_N) begin
                        w_state_nxt = ST_LOCKED;
                        w_good_nxt  = 8'd0;
                        w_bad_nxt   = 8'd0;
                    end else begin
                        w_good_nxt = r_good_cnt + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    if (w_good) begin
                        w_bad_nxt = 8'd0;
                    end else if (r_bad_cnt + 8'd1 >= ERR_N) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_bad_nxt   = 8'd0;
                        w_ferr_set  = 1'b1;
                    end else begin
                        w_bad_nxt = r_bad_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_UNLOCKED;
                    w_good_nxt  = 8'd0;
                    w_bad_nxt   = 8'd0;
                end
            endcase
        end
    end

    // Stage p1: lock FSM and sticky status; a set event beats clr_err
    always_ff @(posedge dsi_clk) begin
        if (!rst_n) begin
            r_state       <= ST_UNLOCKED;
            r_good_cnt    <= 8'd0;
            r_bad_cnt     <= 8'd0;
            r_freq_err    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
            r_bad_cnt  <= w_bad_nxt;
            if (w_ferr_set)
                r_freq_err <= 1'b1;
            else if (clr_err)
                r_freq_err <= 1'b0;
            if (w_tmo)
                r_timeout_err <= 1'b1;
            else if (clr_err)
                r_timeout_err <= 1'b0;
        end
    end

    assign meas_cnt    = r_meas_cnt;
    assign meas_valid  = r_meas_valid;
    assign locked      = (r_state == ST_LOCKED);
    assign freq_err    = r_freq_err;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_dsi_clk_monitor.sv
// Bench for dsi_clk_monitor: table of reference patterns plus hand-written
// timeout, clear and reset sequences; measurements checked via a queue.
module tb_dsi_clk_monitor;

    logic       clk;
    logic       rst_n;
    logic [1:0] div_sel;
    logic       ref_tgl;
    logic       clr_err;
    logic [7:0] meas_cnt;
    logic       meas_valid;
    logic       locked;
    logic       freq_err;
    logic       timeout_err;

    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int cyc = 0;
    int last_tgl = 0;
    bit tb_prime = 1'b1;
    int exp_q[$];

    typedef struct {
        logic [1:0] div;
        int         half;
        int         n;
        logic       lk;
        logic       fe;
        logic       to;
    } vec_t;

    vec_t vecs[8];

    dsi_clk_monitor dut (
        .dsi_clk     (clk),
        .rst_n       (rst_n),
        .div_sel     (div_sel),
        .ref_tgl     (ref_tgl),
        .clr_err     (clr_err),
        .meas_cnt    (meas_cnt),
        .meas_valid  (meas_valid),
        .locked      (locked),
        .freq_err    (freq_err),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every non-priming toggle pushed the interval it closes.
    always @(negedge clk) begin
        if (rst_n && meas_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("meas_unexpected", 1, 0);
            end else begin
                check("meas_cnt", int'(meas_cnt), exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_toggle();
        if (tb_prime)
            tb_prime = 1'b0;
        else
            exp_q.push_back(cyc - last_tgl);
        last_tgl = cyc;
        ref_tgl = ~ref_tgl;
    endtask

    task automatic run_ref(input int half, input int n);
        for (int k = 0; k < n; k++) begin
            do_toggle();
            tick(half);
        end
    endtask

    task automatic check_status(input string tag, input logic lk, input logic fe, input logic to);
        check({tag, "_locked"}, int'(locked), int'(lk));
        check({tag, "_freq_err"}, int'(freq_err), int'(fe));
        check({tag, "_timeout_err"}, int'(timeout_err), int'(to));
    endtask

    initial begin
        int waited;
        int snap;
        vecs[0] = '{div: 2'b01, half: 12, n: 6, lk: 1'b1, fe: 1'b0, to: 1'b0};
        vecs[1] = '{div: 2'b11, half: 3,  n: 8, lk: 1'b1, fe: 1'b0, to: 1'b0};
        vecs[2] = '{div: 2'b10, half: 4,  n: 1, lk: 1'b0, fe: 1'b0, to: 1'b0};
        vecs[3] = '{div: 2'b10, half: 4,  n: 5, lk: 1'b1, fe: 1'b0, to: 1'b0};
        vecs[4] = '{div: 2'b00, half: 6,  n: 6, lk: 1'b1, fe: 1'b0, to: 1'b0};
        vecs[5] = '{div: 2'b00, half: 7,  n: 3, lk: 1'b1, fe: 1'b0, to: 1'b0};
        vecs[6] = '{div: 2'b00, half: 9,  n: 3, lk: 1'b0, fe: 1'b1, to: 1'b0};
        vecs[7] = '{div: 2'b00, half: 6,  n: 6, lk: 1'b1, fe: 1'b1, to: 1'b0};

        rst_n = 1'b0;
        div_sel = 2'b01;
        ref_tgl = 1'b0;
        clr_err = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(1);
        check("rst_meas_cnt", int'(meas_cnt), 0);
        check("rst_meas_valid", int'(meas_valid), 0);
        check_status("rst", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].div != div_sel) begin
                div_sel = vecs[i].div;
                tb_prime = 1'b1;
            end
            run_ref(vecs[i].half, vecs[i].n);
            check_status($sformatf("vec%0d", i), vecs[i].lk, vecs[i].fe, vecs[i].to);
        end

        // Reference stops while locked.
        tick(40);
        check("tmo_early", int'(timeout_err), 0);
        waited = 0;
        while (!timeout_err && waited < 60) begin
            tick(1);
            waited++;
        end
        check("tmo_set", int'(timeout_err), 1);
        check("tmo_unlock", int'(locked), 0);
        check("tmo_fe_kept", int'(freq_err), 1);
        tb_prime = 1'b1;

        run_ref(6, 6);
        check_status("relock", 1'b1, 1'b1, 1'b1);

        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check_status("clr", 1'b1, 1'b0, 1'b0);

        // clr_err coincides with a fresh timeout: cnt hits 63 at 65 cycles after the toggle.
        do_toggle();
        tick(65);
        check("tmo2_pre", int'(timeout_err), 0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("tmo2_set_wins", int'(timeout_err), 1);
        check("tmo2_unlock", int'(locked), 0);
        tb_prime = 1'b1;

        // Reset mid-interval while locked.
        run_ref(6, 6);
        check("pre_rst_locked", int'(locked), 1);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("midrst_meas_cnt", int'(meas_cnt), 0);
        check("midrst_meas_valid", int'(meas_valid), 0);
        check_status("midrst", 1'b0, 1'b0, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tb_prime = 1'b1;
        snap = n_valid;
        do_toggle();
        tick(6);
        check("post_rst_prime_nvalid", n_valid, snap);
        check("post_rst_prime_locked", int'(locked), 0);
        run_ref(6, 5);
        check_status("post_rst_relock", 1'b1, 1'b0, 1'b0);

        tick(6);
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
